interrupt_controller: RTL and testbench

Interrupt priority encoder and IACK-cycle responder for the MAXI030 glue logic, the stage that drives the core's `n_ipl`, `n_avec` and per-device IACK outputs.
- It synchronises seven active-high interrupt requests and masks them through a CPU-visible register.
- It presents the highest pending level to the 68030 and services the CPU's interrupt-acknowledge bus cycle.
- Each IACK cycle ends in one of three ways: a device-supplied vector (per-level IACK strobe), an autovector, or a spurious-interrupt flag.
- The top level inverts its outputs onto the active-low pins and ORs `spurious` into the `n_berr` term.

---
 rtl/interrupt_controller.sv | 174 +++++++++++++++++
 tb/tb_interrupt_controller.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// Interrupt priority encoder and IACK-cycle responder for the 68030 glue logic.
// All outputs are positive logic; the enclosing level inverts them onto the pins.
`timescale 1ns/1ps
module interrupt_controller #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] VECTORED    = 7'b0100000
) (
  input  logic       clock,
  input  logic       n_reset,
  input  logic [6:0] irq,
  input  logic       as,
  input  logic [2:0] fc,
  input  logic [3:0] addr_middle,
  input  logic [2:0] addr_lower,
  input  logic       reg_cs,
  input  logic       reg_sel,
  input  logic       write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic [2:0] ipl,
  output logic [6:0] iack,
  output logic       avec,
  output logic       spurious
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Bit 0 is a dummy "level 0" so the acknowledged level can index directly.
  localparam logic [7:0] VEC_EXT = {VECTORED, 1'b0};

  function automatic logic [2:0] f_highest(input logic [6:0] v);
    logic [2:0] lvl;
    lvl = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (v[i]) lvl = 3'(i + 1);
    end
    return lvl;
  endfunction

  logic [6:0] r_irq_sync [SYNC_STAGES];
  logic [5:0] r_mask;
  state_t     r_state;
  logic [2:0] r_ipl;
  logic [6:0] r_iack;
  logic       r_avec;
  logic       r_spurious;

  logic [6:0] w_irq_s;
  logic [6:0] w_pending;
  logic [7:0] w_pending_ext;
  logic [7:0] w_onehot;
  logic [6:0] w_iack_sel;
  logic       w_iack_cycle;
  logic       w_lvl_pending;
  logic       w_lvl_vectored;
  logic       w_mask_we;
  logic       w_unused_data;

  state_t     w_state_nx;
  logic [2:0] w_ipl_nx;
  logic [6:0] w_iack_nx;
  logic       w_avec_nx;
  logic       w_spur_nx;

  // ---- synchroniser stage
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_irq_sync[i] <= '0;
    end else begin
      r_irq_sync[0] <= irq;
      for (int i = 1; i < SYNC_STAGES; i++) r_irq_sync[i] <= r_irq_sync[i-1];
    end
  end

  assign w_irq_s = r_irq_sync[SYNC_STAGES-1];

  // ---- mask register and combinational pending view
  assign w_mask_we     = reg_cs & write & ~reg_sel;
  assign w_unused_data = data_in[7] ^ data_in[0];

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_mask <= '0;
    end else if (w_mask_we) begin
      r_mask <= data_in[6:1];
    end
  end

  // Level 7 (NMI) bypasses the mask.
  assign w_pending     = w_irq_s & {1'b1, r_mask};
  assign w_pending_ext = {w_pending, 1'b0};

  always_comb begin
    data_out = 8'h00;
    if (reg_cs) begin
      data_out = reg_sel ? {w_pending, 1'b0} : {1'b0, r_mask, 1'b0};
    end
  end

  // ---- IACK decode
  assign w_iack_cycle   = as & (fc == 3'b111) & (addr_middle == 4'hF);
  assign w_lvl_pending  = w_pending_ext[addr_lower];
  assign w_lvl_vectored = VEC_EXT[addr_lower];
  assign w_onehot       = 8'b0000_0001 << addr_lower;
  assign w_iack_sel     = w_onehot[7:1];

  // ---- response state machine
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) r_state <= S_IDLE;
    else          r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_ipl_nx   = r_ipl;
    w_iack_nx  = r_iack;
    w_avec_nx  = r_avec;
    w_spur_nx  = r_spurious;
    case (r_state)
      S_IDLE: begin
        w_ipl_nx  = f_highest(w_pending);
        w_iack_nx = '0;
        w_avec_nx = 1'b0;
        w_spur_nx = 1'b0;
        if (w_iack_cycle) w_state_nx = S_ACK;
      end
      S_ACK: begin
        w_state_nx = S_RESP;
        if (!w_lvl_pending)     w_spur_nx = 1'b1;
        else if (w_lvl_vectored) w_iack_nx = w_iack_sel;
        else                     w_avec_nx = 1'b1;
      end
      S_RESP: begin
        // Strobe persists until the CPU ends the bus cycle; ipl stays frozen.
        if (!as) begin
          w_state_nx = S_IDLE;
          w_iack_nx  = '0;
          w_avec_nx  = 1'b0;
          w_spur_nx  = 1'b0;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_iack_nx  = '0;
        w_avec_nx  = 1'b0;
        w_spur_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_ipl      <= 3'd0;
      r_iack     <= '0;
      r_avec     <= 1'b0;
      r_spurious <= 1'b0;
    end else begin
      r_ipl      <= w_ipl_nx;
      r_iack     <= w_iack_nx;
      r_avec     <= w_avec_nx;
      r_spurious <= w_spur_nx;
    end
  end

  assign ipl      = r_ipl;
  assign iack     = r_iack;
  assign avec     = r_avec;
  assign spurious = r_spurious;

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_interrupt_controller;
  localparam int         SS  = 2;
  localparam logic [6:0] VEC = 7'b0100000;

  logic       clock = 1'b0;
  logic       n_reset = 1'b0;
  logic [6:0] irq = '0;
  logic       as = 1'b0;
  logic [2:0] fc = '0;
  logic [3:0] addr_middle = '0;
  logic [2:0] addr_lower = '0;
  logic       reg_cs = 1'b0;
  logic       reg_sel = 1'b0;
  logic       write = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic [2:0] ipl;
  logic [6:0] iack;
  logic       avec;
  logic       spurious;

  int total = 0;
  int bad = 0;

  // Reference model state: irq history for the sync delay, mask, presented level.
  logic [6:0] m_q[$];
  logic [5:0] m_mask;
  logic [2:0] m_ipl;
  bit         m_frozen;

  interrupt_controller #(.SYNC_STAGES(SS), .VECTORED(VEC)) dut (
    .clock(clock), .n_reset(n_reset), .irq(irq), .as(as), .fc(fc),
    .addr_middle(addr_middle), .addr_lower(addr_lower), .reg_cs(reg_cs),
    .reg_sel(reg_sel), .write(write), .data_in(data_in), .data_out(data_out),
    .ipl(ipl), .iack(iack), .avec(avec), .spurious(spurious)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [6:0] m_pending();
    return m_q[0] & {1'b1, m_mask};
  endfunction

  function automatic logic [2:0] top_level(input logic [6:0] v);
    for (int n = 7; n >= 1; n--) if (v[n-1]) return 3'(n);
    return 3'd0;
  endfunction

  function automatic logic [7:0] exp_dout();
    if (!reg_cs) return 8'h00;
    return reg_sel ? {m_pending(), 1'b0} : {1'b0, m_mask, 1'b0};
  endfunction

  task automatic model_reset();
    m_q.delete();
    repeat (SS) m_q.push_back(7'd0);
    m_mask   = '0;
    m_ipl    = 3'd0;
    m_frozen = 1'b0;
  endtask

  // Applies one clock edge to the model using the inputs present before the edge.
  task automatic model_edge();
    logic [2:0] lvl;
    lvl = top_level(m_pending());
    if (!m_frozen) m_ipl = lvl;
    if (reg_cs && write && !reg_sel) m_mask = data_in[6:1];
    m_q.push_back(irq);
    void'(m_q.pop_front());
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic write_mask(input logic [7:0] v);
    reg_cs = 1'b1; reg_sel = 1'b0; write = 1'b1; data_in = v;
    step();
    write = 1'b0; reg_cs = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    n_reset = 1'b0;
    irq = 7'h7F;
    repeat (3) @(posedge clock);
    #1;
    reg_cs = 1'b1; reg_sel = 1'b0; #1;
    total++; if (ipl !== 3'd0) begin bad++; $display("FAIL rst_ipl: got %0d want 0", ipl); end
    total++; if (iack !== 7'd0) begin bad++; $display("FAIL rst_iack: got %b want 0", iack); end
    total++; if (avec !== 1'b0) begin bad++; $display("FAIL rst_avec: got %b want 0", avec); end
    total++; if (spurious !== 1'b0) begin bad++; $display("FAIL rst_spurious: got %b want 0", spurious); end
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL rst_mask: got %h want 00", data_out); end
    reg_sel = 1'b1; #1;
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL rst_pending: got %h want 00", data_out); end
    reg_cs = 1'b0; reg_sel = 1'b0; irq = '0;
    n_reset = 1'b1;
    step();
  endtask

  task automatic test_basic();
    write_mask(8'h7E);
    irq = 7'b0000010;
    step(); step();
    total++; if (ipl !== 3'd0) begin bad++; $display("FAIL basic_early: got %0d want 0", ipl); end
    step();
    total++; if (ipl !== 3'd2) begin bad++; $display("FAIL basic_ipl: got %0d want 2", ipl); end
    reg_cs = 1'b1; reg_sel = 1'b1; #1;
    total++; if (data_out !== 8'h04) begin bad++; $display("FAIL basic_pending: got %h want 04", data_out); end
    reg_sel = 1'b0; #1;
    total++; if (data_out !== 8'h7E) begin bad++; $display("FAIL basic_mask: got %h want 7e", data_out); end
    reg_cs = 1'b0; #1;
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL basic_cs_low: got %h want 00", data_out); end
  endtask

  task automatic test_nmi();
    write_mask(8'h00);
    irq = 7'b1000101;
    repeat (3) step();
    total++; if (ipl !== 3'd7) begin bad++; $display("FAIL nmi_ipl: got %0d want 7", ipl); end
    reg_cs = 1'b1; reg_sel = 1'b1; #1;
    total++; if (data_out !== 8'h80) begin bad++; $display("FAIL nmi_pending_masked: got %h want 80", data_out); end
    write_mask(8'h7E);
    step();
    total++; if (ipl !== 3'd7) begin bad++; $display("FAIL nmi_ipl_unmasked: got %0d want 7", ipl); end
    reg_cs = 1'b1; reg_sel = 1'b1; #1;
    total++; if (data_out !== 8'h8A) begin bad++; $display("FAIL nmi_pending: got %h want 8a", data_out); end
    reg_cs = 1'b0; reg_sel = 1'b0;
    // mask write to ipl latency: one clock after the write edge
    write_mask(8'h00);
    irq = 7'b0000101;
    repeat (3) step();
    total++; if (ipl !== 3'd0) begin bad++; $display("FAIL mask_all_off: got %0d want 0", ipl); end
    write_mask(8'h7E);
    total++; if (ipl !== 3'd0) begin bad++; $display("FAIL mask_lat_edge: got %0d want 0", ipl); end
    step();
    total++; if (ipl !== 3'd3) begin bad++; $display("FAIL mask_lat_next: got %0d want 3", ipl); end
  endtask

  task automatic test_random_levels();
    for (int c = 0; c < 300; c++) begin
      irq     = 7'($urandom);
      reg_cs  = 1'($urandom);
      reg_sel = 1'($urandom);
      write   = ($urandom_range(0, 3) == 0);
      data_in = 8'($urandom);
      step();
      total++; if (ipl !== m_ipl) begin bad++; $display("FAIL rand_ipl c=%0d: got %0d want %0d", c, ipl, m_ipl); end
      total++; if (data_out !== exp_dout()) begin bad++; $display("FAIL rand_dout c=%0d: got %h want %h", c, data_out, exp_dout()); end
      total++; if ({iack, avec, spurious} !== 9'd0) begin bad++; $display("FAIL rand_strobe c=%0d: got %b want 0", c, {iack, avec, spurious}); end
    end
    write = 1'b0; reg_cs = 1'b0; reg_sel = 1'b0;
  endtask

  // One complete IACK bus cycle with expected outcome taken from the model.
  task automatic do_iack(input logic [2:0] lv, input int hold,
                         input logic [6:0] irq_mid, input bit change_irq);
    logic [2:0] exp_ipl;
    logic [6:0] pend;
    logic [6:0] e_iack;
    logic       e_avec;
    logic       e_sp;
    int         idx;
    as = 1'b1; fc = 3'b111; addr_middle = 4'hF; addr_lower = lv;
    step();
    total++; if ({iack, avec, spurious} !== 9'd0) begin bad++; $display("FAIL iack_early L=%0d: got %b want 0", lv, {iack, avec, spurious}); end
    total++; if (ipl !== m_ipl) begin bad++; $display("FAIL iack_ipl_entry L=%0d: got %0d want %0d", lv, ipl, m_ipl); end
    m_frozen = 1'b1;
    exp_ipl  = m_ipl;
    pend     = m_pending();
    idx      = int'(lv) - 1;
    e_iack = '0; e_avec = 1'b0; e_sp = 1'b0;
    if (lv == 3'd0) e_sp = 1'b1;
    else if (!pend[idx]) e_sp = 1'b1;
    else if (VEC[idx]) e_iack[idx] = 1'b1;
    else e_avec = 1'b1;
    step();
    total++; if ({iack, avec, spurious} !== {e_iack, e_avec, e_sp}) begin bad++; $display("FAIL iack_resp L=%0d: got %b want %b", lv, {iack, avec, spurious}, {e_iack, e_avec, e_sp}); end
    total++; if (ipl !== exp_ipl) begin bad++; $display("FAIL iack_ipl_frozen L=%0d: got %0d want %0d", lv, ipl, exp_ipl); end
    for (int i = 0; i < hold; i++) begin
      if (i == 0 && change_irq) irq = irq_mid;
      step();
      total++; if ({iack, avec, spurious} !== {e_iack, e_avec, e_sp}) begin bad++; $display("FAIL iack_hold L=%0d i=%0d: got %b want %b", lv, i, {iack, avec, spurious}, {e_iack, e_avec, e_sp}); end
      total++; if (ipl !== exp_ipl) begin bad++; $display("FAIL iack_ipl_hold L=%0d i=%0d: got %0d want %0d", lv, i, ipl, exp_ipl); end
    end
    as = 1'b0;
    step();
    total++; if ({iack, avec, spurious} !== 9'd0) begin bad++; $display("FAIL iack_release L=%0d: got %b want 0", lv, {iack, avec, spurious}); end
    total++; if (ipl !== exp_ipl) begin bad++; $display("FAIL iack_ipl_release L=%0d: got %0d want %0d", lv, ipl, exp_ipl); end
    m_frozen = 1'b0;
    step();
    total++; if (ipl !== m_ipl) begin bad++; $display("FAIL iack_ipl_idle L=%0d: got %0d want %0d", lv, ipl, m_ipl); end
  endtask

  task automatic test_autovec();
    write_mask(8'h7E);
    irq = 7'b0000010;
    repeat (3) step();
    total++; if (ipl !== 3'd2) begin bad++; $display("FAIL av_pre_ipl: got %0d want 2", ipl); end
    do_iack(3'd2, 4, 7'b0100010, 1'b1);
    total++; if (ipl !== 3'd6) begin bad++; $display("FAIL av_post_ipl: got %0d want 6", ipl); end
  endtask

  task automatic test_vectored();
    irq = 7'b0100000;
    repeat (3) step();
    total++; if (ipl !== 3'd6) begin bad++; $display("FAIL vec_pre_ipl: got %0d want 6", ipl); end
    do_iack(3'd6, 3, 7'b0000000, 1'b1);
    total++; if (ipl !== 3'd0) begin bad++; $display("FAIL vec_post_ipl: got %0d want 0", ipl); end
  endtask

  task automatic test_spurious();
    irq = 7'b0000000;
    repeat (3) step();
    do_iack(3'd3, 2, 7'b0, 1'b0);
    do_iack(3'd0, 1, 7'b0, 1'b0);
  endtask

  task automatic test_non_iack();
    irq = 7'b0001000;
    as = 1'b1; fc = 3'b101; addr_middle = 4'hF; addr_lower = 3'd4;
    repeat (4) begin
      step();
      total++; if ({iack, avec, spurious} !== 9'd0) begin bad++; $display("FAIL noniack_fc: got %b want 0", {iack, avec, spurious}); end
    end
    fc = 3'b111; addr_middle = 4'hE;
    repeat (4) begin
      step();
      total++; if ({iack, avec, spurious} !== 9'd0) begin bad++; $display("FAIL noniack_addr: got %b want 0", {iack, avec, spurious}); end
      total++; if (ipl !== m_ipl) begin bad++; $display("FAIL noniack_ipl: got %0d want %0d", ipl, m_ipl); end
    end
    as = 1'b0;
    step();
  endtask

  task automatic test_random_iack();
    for (int t = 0; t < 16; t++) begin
      irq = 7'($urandom);
      write_mask(8'($urandom));
      repeat ($urandom_range(0, 3)) step();
      do_iack(3'($urandom_range(0, 7)), $urandom_range(0, 3), 7'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_reset_mid();
    write_mask(8'h7E);
    irq = 7'b0000010;
    repeat (3) step();
    reg_cs = 1'b1; reg_sel = 1'b0; #1;
    total++; if (data_out !== 8'h7E) begin bad++; $display("FAIL rmid_mask_pre: got %h want 7e", data_out); end
    as = 1'b1; fc = 3'b111; addr_middle = 4'hF; addr_lower = 3'd2;
    step();
    m_frozen = 1'b1;
    step(); step();
    total++; if (avec !== 1'b1) begin bad++; $display("FAIL rmid_avec_pre: got %b want 1", avec); end
    #2;
    n_reset = 1'b0;
    #1;
    model_reset();
    total++; if (avec !== 1'b0) begin bad++; $display("FAIL rmid_avec: got %b want 0", avec); end
    total++; if (ipl !== 3'd0) begin bad++; $display("FAIL rmid_ipl: got %0d want 0", ipl); end
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL rmid_mask: got %h want 00", data_out); end
    total++; if ({iack, spurious} !== 8'd0) begin bad++; $display("FAIL rmid_strobes: got %b want 0", {iack, spurious}); end
    as = 1'b0; reg_cs = 1'b0;
    irq = 7'b1000000;
    @(negedge clock);
    n_reset = 1'b1;
    step();
    total++; if (ipl !== 3'd0) begin bad++; $display("FAIL rmid_post1: got %0d want 0", ipl); end
    step();
    total++; if (ipl !== 3'd0) begin bad++; $display("FAIL rmid_post2: got %0d want 0", ipl); end
    step();
    total++; if (ipl !== 3'd7) begin bad++; $display("FAIL rmid_post3: got %0d want 7", ipl); end
    total++; if (ipl !== m_ipl) begin bad++; $display("FAIL rmid_model: got %0d want %0d", ipl, m_ipl); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_nmi();
    test_random_levels();
    test_autovec();
    test_vectored();
    test_spurious();
    test_non_iack();
    test_random_iack();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
